// File: rtl/multiplier_acc_seq.sv
// Sequential multiply-accumulate: result = a*b + c via MSB-first shift-and-add,
// one bit of a per clock, with valid/ready handshakes on both sides.
module multiplier_acc_seq #(
    parameter int unsigned N = 6,
    parameter int unsigned M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [M-1:0]     b,
    input  logic [M-1:0]     c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   result
);

    localparam int unsigned W  = N + M;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [M-1:0]    b_q, b_d;
    logic [M-1:0]    c_q, c_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;

    logic [W-1:0]    partial;
    logic [W-1:0]    step;
    logic [W-1:0]    final_sum;

    always_comb begin
        partial   = a_q[cnt_q] ? {{N{1'b0}}, b_q} : '0;
        step      = (acc_q << 1) + partial;
        final_sum = step + {{N{1'b0}}, c_q};

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    acc_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // cnt steps every CALC edge so the N bits of a take exactly N edges
                if (cnt_q == '0) begin
                    acc_d    = final_sum;
                    result_d = final_sum;
                    state_d  = StDone;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;

endmodule

// File: tb/tb_multiplier_acc_seq.sv
// Directed bench for multiplier_acc_seq (N=6, M=4) with hand-computed results.
module tb_multiplier_acc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    multiplier_acc_seq #(.N(6), .M(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, hold out_ready low for 'hold' cycles after out_valid.
    task automatic run_op(input string tag, input int ai, input int bi, input int ci,
                          input int exp, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_in_ready"}, int'(in_ready), 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a = 6'(ai);
        b = 4'(bi);
        c = 4'(ci);
        tick();
        in_valid = 1'b0;
        a = ~6'(ai);
        b = ~4'(bi);
        c = ~4'(ci);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, n, 6);
        check_eq({tag, "_result"}, int'(result), exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, "_hold_valid"}, int'(out_valid), 1);
            check_eq({tag, "_hold_result"}, int'(result), exp);
            check_eq({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check_eq({tag, "_drop_valid"}, int'(out_valid), 0);
        check_eq({tag, "_back_idle"}, int'(in_ready), 1);
        check_eq({tag, "_result_kept"}, int'(result), exp);
    endtask

    int ops_a [3] = '{7, 33, 50};
    int ops_b [3] = '{9, 5, 12};
    int ops_c [3] = '{2, 14, 3};
    int ops_r [3] = '{65, 179, 603};

    initial begin
        int n;
        int acc_cyc;
        int prev_cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        c = '0;
        repeat (3) tick();
        check_eq("reset_in_ready", int'(in_ready), 1);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_result", int'(result), 0);
        rst = 1'b0;
        tick();

        run_op("basic", 45, 11, 7, 502, 0);
        run_op("max", 63, 15, 15, 960, 0);
        run_op("b_zero", 63, 0, 9, 9, 0);
        run_op("a_zero", 0, 15, 3, 3, 0);
        run_op("one", 1, 1, 0, 1, 0);
        run_op("backpressure", 10, 10, 0, 100, 5);

        // Reset three edges after acceptance discards the operation.
        in_valid = 1'b1;
        a = 6'd20;
        b = 4'd9;
        c = 4'd4;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_result", int'(result), 0);
        check_eq("midrst_in_ready", int'(in_ready), 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) n++;
        end
        check_eq("midrst_no_pulse", n, 0);
        run_op("after_rst", 5, 3, 1, 16, 0);

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_cyc  = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            a = 6'(ops_a[i]);
            b = 4'(ops_b[i]);
            c = 4'(ops_c[i]);
            tick();
            acc_cyc = cyc;
            a = 6'(ops_a[(i + 1) % 3]);
            b = 4'(ops_b[(i + 1) % 3]);
            c = 4'(ops_c[(i + 1) % 3]);
            if (i > 0) check_eq("b2b_interval", acc_cyc - prev_cyc, 8);
            prev_cyc = acc_cyc;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            check_eq("b2b_latency", n, 6);
            check_eq("b2b_result", int'(result), ops_r[i]);
        end
        in_valid = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
